// File: rtl/reduce_combine.sv
// -----------------------------------------------------------------------------
// reduce_combine
//   Consumer end of the reduce-instruction FIFO. Each entry is {children, flit}
//   and is already addressed to the reduction root. Payloads that belong to the
//   same (contextId, tag) operation are merged in a small reduction table. Once
//   every contribution has arrived, one flit carrying the combined payload is
//   sent upstream. Leaf entries (children == 0) and entries with an unsupported
//   op skip the table and are forwarded unchanged.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   in_data      {children, flit} from the reduce FIFO
//   in_valid     in_data valid
//   in_ready     entry accepted on the clk edge when in_valid & in_ready
//   out_flit     combined / forwarded flit (registered)
//   out_valid    out_flit valid (registered)
//   out_ready    downstream accepts on out_valid & out_ready
//   op_mismatch  one-cycle pulse: a merged packet's op differed from the entry op
//   table_full   all table entries busy (registered)
// -----------------------------------------------------------------------------
module reduce_combine #(
    parameter int FlitWidth     = 73,
    parameter int ChildrenWidth = 3,
    parameter int PayloadWidth  = 32,
    parameter int OpPos         = 32,
    parameter int TagPos        = 38,
    parameter int ContextIdPos  = 46,
    parameter int TableDepth    = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [FlitWidth+ChildrenWidth-1:0]    in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [FlitWidth-1:0]                  out_flit,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  op_mismatch,
    output logic                                  table_full
);

    localparam int HdrWidth = FlitWidth - PayloadWidth;
    localparam int RemWidth = ChildrenWidth + 1;
    localparam int IdxWidth = (TableDepth > 1) ? $clog2(TableDepth) : 1;
    localparam int ValidPos = FlitWidth - 1;

    // Combine two payloads according to the entry op; unsupported ops never
    // reach the table, so the default arm is only a safe fallback.
    function automatic logic [PayloadWidth-1:0] combine(
        input logic [3:0]              op,
        input logic [PayloadWidth-1:0] a,
        input logic [PayloadWidth-1:0] b
    );
        logic [PayloadWidth-1:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = ($signed(a) > $signed(b)) ? a : b;
            4'd2:    r = ($signed(a) < $signed(b)) ? a : b;
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    // Reduction table state
    logic [TableDepth-1:0]                    busy_q, busy_d;
    logic [TableDepth-1:0][7:0]               ctx_q, ctx_d;
    logic [TableDepth-1:0][7:0]               tag_q, tag_d;
    logic [TableDepth-1:0][3:0]               op_q, op_d;
    logic [TableDepth-1:0][RemWidth-1:0]      rem_q, rem_d;
    logic [TableDepth-1:0][PayloadWidth-1:0]  acc_q, acc_d;
    logic [TableDepth-1:0][HdrWidth-1:0]      hdr_q, hdr_d;

    // Output-side state
    logic [FlitWidth-1:0] out_flit_q, out_flit_d;
    logic                 out_valid_q, out_valid_d;
    logic                 op_mismatch_q, op_mismatch_d;
    logic                 table_full_q, table_full_d;

    // Decoded input fields
    logic [ChildrenWidth-1:0] in_children_s;
    logic [FlitWidth-1:0]     in_flit_s;
    logic                     in_vbit_s;
    logic [7:0]               in_ctx_s;
    logic [7:0]               in_tag_s;
    logic [3:0]               in_op_s;
    logic [PayloadWidth-1:0]  in_payload_s;
    logic                     leaf_s;
    logic                     unsup_s;

    logic                     match_s;
    logic [IdxWidth-1:0]      match_idx_s;
    logic                     free_s;
    logic [IdxWidth-1:0]      free_idx_s;
    logic                     out_ok_s;
    logic                     accept_s;
    logic [PayloadWidth-1:0]  acc_new_s;

    assign in_children_s = in_data[FlitWidth +: ChildrenWidth];
    assign in_flit_s     = in_data[FlitWidth-1:0];
    assign in_vbit_s     = in_data[ValidPos];
    assign in_ctx_s      = in_data[ContextIdPos +: 8];
    assign in_tag_s      = in_data[TagPos +: 8];
    assign in_op_s       = in_data[OpPos +: 4];
    assign in_payload_s  = in_data[PayloadWidth-1:0];
    assign leaf_s        = (in_children_s == {ChildrenWidth{1'b0}});
    assign unsup_s       = (in_op_s > 4'd5);

    // Key lookup and lowest-index free-slot search over the table
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = {IdxWidth{1'b0}};
        free_s      = 1'b0;
        free_idx_s  = {IdxWidth{1'b0}};
        // Walk downwards so the last free hit is the lowest index.
        for (int i = TableDepth - 1; i >= 0; i--) begin
            if (busy_q[i] && (ctx_q[i] == in_ctx_s) && (tag_q[i] == in_tag_s)) begin
                match_s     = 1'b1;
                match_idx_s = IdxWidth'(i);
            end else begin
                match_s     = match_s;
            end
            if (!busy_q[i]) begin
                free_s     = 1'b1;
                free_idx_s = IdxWidth'(i);
            end else begin
                free_s     = free_s;
            end
        end
    end

    // Output register may be written only when empty or draining this cycle;
    // every accepted entry may write it, so acceptance is gated on that.
    assign out_ok_s = !out_valid_q || out_ready;
    assign in_ready = !rst && out_ok_s &&
                      (leaf_s || match_s || free_s || unsup_s || !in_vbit_s);
    assign accept_s = in_valid && in_ready;
    assign acc_new_s = combine(op_q[match_idx_s], acc_q[match_idx_s], in_payload_s);

    // Next-state logic for the table and output registers
    always_comb begin
        busy_d        = busy_q;
        ctx_d         = ctx_q;
        tag_d         = tag_q;
        op_d          = op_q;
        rem_d         = rem_q;
        acc_d         = acc_q;
        hdr_d         = hdr_q;
        out_flit_d    = out_flit_q;
        out_valid_d   = out_valid_q && !out_ready;
        op_mismatch_d = 1'b0;

        if (accept_s && in_vbit_s) begin
            if (leaf_s || unsup_s) begin
                out_flit_d  = in_flit_s;
                out_valid_d = 1'b1;
            end else if (match_s) begin
                // The entry op wins; a differing packet op is only flagged.
                op_mismatch_d = (in_op_s != op_q[match_idx_s]);
                if (rem_q[match_idx_s] == RemWidth'(1)) begin
                    busy_d[match_idx_s] = 1'b0;
                    out_flit_d          = {hdr_q[match_idx_s], acc_new_s};
                    out_valid_d         = 1'b1;
                end else begin
                    rem_d[match_idx_s] = rem_q[match_idx_s] - RemWidth'(1);
                    acc_d[match_idx_s] = acc_new_s;
                end
            end else begin
                // First contribution: children more are still to come.
                busy_d[free_idx_s] = 1'b1;
                ctx_d[free_idx_s]  = in_ctx_s;
                tag_d[free_idx_s]  = in_tag_s;
                op_d[free_idx_s]   = in_op_s;
                rem_d[free_idx_s]  = {1'b0, in_children_s};
                acc_d[free_idx_s]  = in_payload_s;
                hdr_d[free_idx_s]  = in_flit_s[FlitWidth-1:PayloadWidth];
            end
        end else begin
            busy_d = busy_q;
        end

        table_full_d = &busy_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= {TableDepth{1'b0}};
            ctx_q         <= '0;
            tag_q         <= '0;
            op_q          <= '0;
            rem_q         <= '0;
            acc_q         <= '0;
            hdr_q         <= '0;
            out_flit_q    <= {FlitWidth{1'b0}};
            out_valid_q   <= 1'b0;
            op_mismatch_q <= 1'b0;
            table_full_q  <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            ctx_q         <= ctx_d;
            tag_q         <= tag_d;
            op_q          <= op_d;
            rem_q         <= rem_d;
            acc_q         <= acc_d;
            hdr_q         <= hdr_d;
            out_flit_q    <= out_flit_d;
            out_valid_q   <= out_valid_d;
            op_mismatch_q <= op_mismatch_d;
            table_full_q  <= table_full_d;
        end
    end

    assign out_flit    = out_flit_q;
    assign out_valid   = out_valid_q;
    assign op_mismatch = op_mismatch_q;
    assign table_full  = table_full_q;

endmodule

// File: tb/tb_reduce_combine.sv
// -----------------------------------------------------------------------------
// tb_reduce_combine
//   Directed-vector bench for reduce_combine. Inputs are driven 1 time unit
//   after the rising edge and outputs are sampled at that point, away from the
//   active edge. Expected flits are built from the same field packer used for
//   stimulus, with hand-computed payloads.
// -----------------------------------------------------------------------------
module tb_reduce_combine;

    logic        clk;
    logic        rst;
    logic [75:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [72:0] out_flit;
    logic        out_valid;
    logic        out_ready;
    logic        op_mismatch;
    logic        table_full;

    int checks   = 0;
    int failures = 0;

    reduce_combine dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_mismatch(op_mismatch),
        .table_full (table_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic check_eq(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pack {children, flit}: valid=1, fixed upper header, ctx, tag, op, payload.
    function automatic logic [75:0] mk(input logic [2:0] ch, input logic [7:0] ctx,
                                       input logic [7:0] tag, input logic [3:0] op,
                                       input logic [31:0] pl);
        logic [75:0] d;
        d         = 76'd0;
        d[75:73]  = ch;
        d[72]     = 1'b1;
        d[71:54]  = 18'h12345;
        d[53:46]  = ctx;
        d[45:38]  = tag;
        d[37:36]  = 2'b00;
        d[35:32]  = op;
        d[31:0]   = pl;
        return d;
    endfunction

    // Offer one entry and hold it until accepted (bounded wait).
    task automatic send(input logic [75:0] d);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check_eq("send_timeout", 73'(in_ready), 73'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [75:0] d;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 76'd0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_out_valid", 73'(out_valid), 73'd0);
        check_eq("rst_out_flit", out_flit, 73'd0);
        check_eq("rst_table_full", 73'(table_full), 73'd0);
        check_eq("rst_op_mismatch", 73'(op_mismatch), 73'd0);
        in_data  = mk(3'd0, 8'd0, 8'd0, 4'd0, 32'd5);
        in_valid = 1'b1;
        #1;
        check_eq("rst_in_ready", 73'(in_ready), 73'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // T1 leaf forward
        d = mk(3'd0, 8'd0, 8'd0, 4'd0, 32'd5);
        send(d);
        check_eq("t1_valid", 73'(out_valid), 73'd1);
        check_eq("t1_flit", out_flit, d[72:0]);
        tick();
        check_eq("t1_drained", 73'(out_valid), 73'd0);

        // T2 sum of four contributions
        send(mk(3'd3, 8'd0, 8'd1, 4'd0, 32'd1));
        check_eq("t2_no_out1", 73'(out_valid), 73'd0);
        send(mk(3'd3, 8'd0, 8'd1, 4'd0, 32'd2));
        check_eq("t2_no_out2", 73'(out_valid), 73'd0);
        send(mk(3'd3, 8'd0, 8'd1, 4'd0, 32'd3));
        check_eq("t2_no_out3", 73'(out_valid), 73'd0);
        send(mk(3'd3, 8'd0, 8'd1, 4'd0, 32'd4));
        check_eq("t2_valid", 73'(out_valid), 73'd1);
        d = mk(3'd3, 8'd0, 8'd1, 4'd0, 32'd10);
        check_eq("t2_sum", out_flit, d[72:0]);

        // T3 signed max / min, plus xor
        send(mk(3'd1, 8'd0, 8'd2, 4'd1, 32'hFFFF_FFFF));
        send(mk(3'd1, 8'd0, 8'd2, 4'd1, 32'h0000_0002));
        d = mk(3'd1, 8'd0, 8'd2, 4'd1, 32'h0000_0002);
        check_eq("t3_max", out_flit, d[72:0]);
        send(mk(3'd1, 8'd0, 8'd3, 4'd2, 32'hFFFF_FFFF));
        send(mk(3'd1, 8'd0, 8'd3, 4'd2, 32'h0000_0002));
        d = mk(3'd1, 8'd0, 8'd3, 4'd2, 32'hFFFF_FFFF);
        check_eq("t3_min", out_flit, d[72:0]);
        send(mk(3'd1, 8'd5, 8'd4, 4'd5, 32'hF0F0_F0F0));
        send(mk(3'd1, 8'd5, 8'd4, 4'd5, 32'hFF00_FF00));
        d = mk(3'd1, 8'd5, 8'd4, 4'd5, 32'h0FF0_0FF0);
        check_eq("t3_xor", out_flit, d[72:0]);

        // Unsupported op forwarded unchanged; invalid entry dropped
        d = mk(3'd2, 8'd0, 8'd9, 4'd7, 32'h1234_5678);
        send(d);
        check_eq("unsup_fwd", out_flit, d[72:0]);
        check_eq("unsup_full", 73'(table_full), 73'd0);
        d = mk(3'd0, 8'd0, 8'd0, 4'd0, 32'd99);
        d[72] = 1'b0;
        tick();
        send(d);
        check_eq("drop_invalid", 73'(out_valid), 73'd0);

        // T4 fill the table, block a fifth key, free a slot
        for (int t = 1; t <= 4; t++) begin
            send(mk(3'd1, 8'd1, 8'(t), 4'd0, 32'(10 * t)));
        end
        check_eq("t4_full", 73'(table_full), 73'd1);
        in_data  = mk(3'd1, 8'd1, 8'd5, 4'd0, 32'd50);
        in_valid = 1'b1;
        #1;
        check_eq("t4_blocked", 73'(in_ready), 73'd0);
        in_valid = 1'b0;
        send(mk(3'd1, 8'd1, 8'd2, 4'd0, 32'd1));
        d = mk(3'd1, 8'd1, 8'd2, 4'd0, 32'd21);
        check_eq("t4_complete", out_flit, d[72:0]);
        check_eq("t4_not_full", 73'(table_full), 73'd0);
        send(mk(3'd1, 8'd1, 8'd5, 4'd0, 32'd50));
        check_eq("t4_refull", 73'(table_full), 73'd1);
        send(mk(3'd1, 8'd1, 8'd5, 4'd0, 32'd5));
        d = mk(3'd1, 8'd1, 8'd5, 4'd0, 32'd55);
        check_eq("t4_tag5", out_flit, d[72:0]);
        for (int t = 1; t <= 4; t++) begin
            if (t != 2) send(mk(3'd1, 8'd1, 8'(t), 4'd0, 32'd1));
        end
        check_eq("t4_empty", 73'(table_full), 73'd0);

        // T5 backpressure: hold output, block completion, then drain + accept
        tick();
        send(mk(3'd1, 8'd2, 8'd6, 4'd0, 32'd100));
        out_ready = 1'b0;
        d = mk(3'd0, 8'd2, 8'd0, 4'd3, 32'hAAAA_5555);
        send(d);
        check_eq("t5_held_valid", 73'(out_valid), 73'd1);
        in_data  = mk(3'd1, 8'd2, 8'd6, 4'd0, 32'd5);
        in_valid = 1'b1;
        #1;
        check_eq("t5_blocked", 73'(in_ready), 73'd0);
        tick();
        tick();
        check_eq("t5_stable", out_flit, d[72:0]);
        out_ready = 1'b1;
        #1;
        check_eq("t5_ready", 73'(in_ready), 73'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        d = mk(3'd1, 8'd2, 8'd6, 4'd0, 32'd105);
        check_eq("t5_refill_valid", 73'(out_valid), 73'd1);
        check_eq("t5_refill_flit", out_flit, d[72:0]);

        // T6 op mismatch: entry op (sum) wins
        send(mk(3'd1, 8'd3, 8'd7, 4'd0, 32'd7));
        send(mk(3'd1, 8'd3, 8'd7, 4'd4, 32'd8));
        check_eq("t6_mismatch", 73'(op_mismatch), 73'd1);
        d = mk(3'd1, 8'd3, 8'd7, 4'd0, 32'd15);
        check_eq("t6_sum_used", out_flit, d[72:0]);
        tick();
        check_eq("t6_pulse_end", 73'(op_mismatch), 73'd0);

        // T6 reset mid-operation discards partials
        for (int t = 8; t <= 11; t++) begin
            send(mk(3'd2, 8'd4, 8'(t), 4'd0, 32'd1));
        end
        check_eq("t6_full", 73'(table_full), 73'd1);
        rst = 1'b1;
        tick();
        tick();
        check_eq("t6_rst_full", 73'(table_full), 73'd0);
        check_eq("t6_rst_valid", 73'(out_valid), 73'd0);
        rst = 1'b0;
        tick();
        send(mk(3'd2, 8'd4, 8'd8, 4'd0, 32'd2));
        check_eq("t6_fresh1", 73'(out_valid), 73'd0);
        send(mk(3'd2, 8'd4, 8'd8, 4'd0, 32'd3));
        check_eq("t6_fresh2", 73'(out_valid), 73'd0);
        send(mk(3'd2, 8'd4, 8'd8, 4'd0, 32'd4));
        d = mk(3'd2, 8'd4, 8'd8, 4'd0, 32'd9);
        check_eq("t6_fresh_sum", out_flit, d[72:0]);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
